mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Data-side memory responder for the LC-3b pipeline: the far end of the MEM-stage
//  request interface (mem_address/mem_read/mem_write/mem_wdata -> mem_rdata/mem_resp).
//  Backs a word array with configurable fixed latency and byte-enabled writes. Serves
//  as synthesizable stand-in for the data cache until the cache hierarchy lands, and
//  as the slave model in pipeline benches.
// PARAMETERS
//  DEPTH    256  storage size in 16-bit words (power of two, >= 2)
//  LATENCY  2    cycles from request acceptance to mem_resp (>= 1)
// PORTS
//  clk              in   1   clock; all state updates on rising edge
//  rst              in   1   synchronous, active-high reset
//  mem_address      in   16  byte address; bit 0 ignored, bits [$clog2(DEPTH):1] index
//  mem_read         in   1   read request, held by requester until mem_resp
//  mem_write        in   1   write request, held by requester until mem_resp
//  mem_byte_enable  in   2   write lanes: [1]=bits 15:8, [0]=bits 7:0
//  mem_wdata        in   16  write data
//  mem_rdata        out  16  read data, valid in the mem_resp cycle, held until next read completes
//  mem_resp         out  1   one-cycle completion pulse
//  protocol_err     out  1   sticky flag: read and write asserted together
// BEHAVIOUR
//  - Reset: mem_rdata=0, mem_resp=0, protocol_err=0, state=IDLE, counter=0. Array
//    contents NOT cleared (retained across reset). Reset mid-transaction aborts it:
//    no mem_resp, pending write not performed.
//  - States: IDLE, BUSY, RESP.
//    IDLE: (mem_read|mem_write)=1 -> latch address index, op, byte_enable, wdata;
//      counter=LATENCY-1; go BUSY if LATENCY>1, else RESP.
//    BUSY: decrement counter; at 1 -> RESP. Inputs ignored (latched copy used).
//    RESP: mem_resp=1 for exactly this cycle; write committed to array at end of this
//      cycle; read data (array at latched index) driven on mem_rdata this cycle. -> IDLE.
//  - Timing: request seen in IDLE at cycle t -> mem_resp high at cycle t+LATENCY.
//    Back-to-back: after RESP, one IDLE cycle minimum before next acceptance; a request
//    still asserted in that IDLE cycle is a NEW request (requester must drop or re-issue).
//  - mem_resp registered output (no combinational path from inputs).
//  - Writes: lane written only where byte_enable bit set; byte_enable=00 completes with
//    mem_resp and changes nothing. mem_rdata unchanged on write completion.
//  - Read-after-write to same address in next transaction returns new data.
//  - Read and write both high in IDLE: treated as write, protocol_err set and held until rst.
//  - Address wrap: index bits above $clog2(DEPTH) ignored (aliasing), no error.
// STRUCTURE
//  - lc3b_types: add lc3b_mem_wmask (logic [1:0]) and enum mem_resp_state_t {IDLE,BUSY,RESP}.
//  - Sub-module mem_responder_array: DEPTH x 16 array, one sync write port with 2-bit
//    mask, one async read port. Top holds FSM, latency counter, request latches.
// TESTING
//  - Reset, read @0x0010 (LATENCY=2), array preloaded 0xBEEF -> resp at t+2, rdata=0xBEEF, resp 1 cycle.
//  - Write 0x1234 @0x0020 mask 11, then read @0x0020 -> rdata=0x1234; write 0xAB00 mask 10 -> read 0xAB34.
//  - Change mem_address/mem_wdata during BUSY -> completion uses values latched at acceptance.
//  - Read+write both high, wdata 0x5555 @0x0030 -> treated as write, protocol_err=1 until rst.
//  - rst asserted in BUSY of write 0x7777 @0x0040 -> no mem_resp, later read @0x0040 returns old value.
//  - LATENCY=1 and DEPTH=256: read @0x0202 aliases index 1 -> resp at t+1, data of @0x0002.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for the data-side memory responder.
//   lc3b_mem_wmask   : 2-bit write lane mask, [1]=bits 15:8, [0]=bits 7:0
//   mem_resp_state_t : responder FSM states
package mem_responder_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef logic [1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// MEM-stage request interface between the pipeline (master) and the memory
// responder (slave).
//   mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata : master -> slave
//   mem_rdata/mem_resp/protocol_err                          : slave -> master
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [MEM_ADDR_W-1:0] mem_address;
  logic                  mem_read;
  logic                  mem_write;
  lc3b_mem_wmask         mem_byte_enable;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic [MEM_DATA_W-1:0] mem_rdata;
  logic                  mem_resp;
  logic                  protocol_err;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, protocol_err
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, protocol_err
  );
endinterface

// File: rtl/mem_responder_array.sv
// DEPTH x 16 word storage for the memory responder.
//   clk   : clock
//   we    : write strobe, commits on the rising edge
//   wmask : per-byte lane enable for the write
//   waddr : write word index
//   wdata : write data
//   raddr : asynchronous read word index
//   rdata : asynchronous read data
// Contents have no reset; they survive a responder reset.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  lc3b_mem_wmask         wmask,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [MEM_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [MEM_DATA_W-1:0] rdata
);

  logic [MEM_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem_q[waddr][7:0]  <= wdata[7:0];
      if (wmask[1]) mem_q[waddr][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency data memory responder for the LC-3b MEM stage.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset (control state and read data only)
//   bus : slave side of mem_responder_if
// A request seen in IDLE is latched and answered LATENCY cycles later with a
// one-cycle mem_resp. Writes commit at the end of the response cycle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  is_wr_q, is_wr_d;
  lc3b_mem_wmask         be_q, be_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  perr_q, perr_d;

  logic [IDX_W-1:0]      in_idx;
  logic [IDX_W-1:0]      arr_raddr;
  logic [MEM_DATA_W-1:0] arr_rdata;
  logic                  arr_we;
  logic                  unused_addr_bits;

  // Upper address bits alias onto the array; byte bit 0 is ignored.
  assign in_idx           = bus.mem_address[IDX_W:1];
  assign unused_addr_bits = ^{bus.mem_address[MEM_ADDR_W-1:IDX_W+1], bus.mem_address[0]};

  // With LATENCY=1 the read happens on the accepting edge, so the array must
  // be addressed from the live bus while idle and from the latch afterwards.
  assign arr_raddr = (state_q == IDLE) ? in_idx : idx_q;

  // Gated by rst so a reset landing in the response cycle drops the write.
  assign arr_we = (state_q == RESP) && is_wr_q && !rst;

  mem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .wmask (be_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    is_wr_d = is_wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    perr_d  = perr_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          idx_d   = in_idx;
          // Simultaneous read+write resolves to a write and flags the requester.
          is_wr_d = bus.mem_write;
          be_d    = bus.mem_byte_enable;
          wdata_d = bus.mem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (bus.mem_read && bus.mem_write) perr_d = 1'b1;
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = RESP;
            resp_d  = 1'b1;
            if (!bus.mem_write) rdata_d = arr_rdata;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          resp_d  = 1'b1;
          if (!is_wr_q) rdata_d = arr_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    is_wr_q <= is_wr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.mem_rdata    = rdata_q;
  assign bus.mem_resp     = resp_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 and one LATENCY=1 instance, directed
// scenarios followed by random traffic against a word-array reference model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] addr, wdata;
  logic        rd, wr, sel;
  logic [1:0]  be;

  mem_responder_if bus0();
  mem_responder_if bus1();

  assign bus0.mem_address     = addr;
  assign bus0.mem_wdata       = wdata;
  assign bus0.mem_byte_enable = be;
  assign bus0.mem_read        = rd & ~sel;
  assign bus0.mem_write       = wr & ~sel;
  assign bus1.mem_address     = addr;
  assign bus1.mem_wdata       = wdata;
  assign bus1.mem_byte_enable = be;
  assign bus1.mem_read        = rd & sel;
  assign bus1.mem_write       = wr & sel;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int errors = 0;
  int checks = 0;

  // Reference state, one slot per instance.
  int          lat [2] = '{2, 1};
  logic [15:0] ref_mem   [2][DEPTH];
  bit          ref_known [2][DEPTH];
  logic [15:0] ref_rdata [2];
  bit          ref_perr  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_resp(input int d);
    return (d != 0) ? bus1.mem_resp : bus0.mem_resp;
  endfunction

  function automatic logic [15:0] get_rdata(input int d);
    return (d != 0) ? bus1.mem_rdata : bus0.mem_rdata;
  endfunction

  function automatic logic get_perr(input int d);
    return (d != 0) ? bus1.protocol_err : bus0.protocol_err;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      ref_rdata[d] = 16'h0;
      ref_perr[d]  = 1'b0;
    end
  endtask

  // One complete transaction: hold the request until mem_resp, then drop it
  // and confirm the pulse lasted a single cycle.
  task automatic txn(input int d, input bit do_rd, input bit do_wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] m, input bit scramble,
                     input string tag);
    int n;
    bit got;
    int i;
    sel = (d != 0);
    addr = a; wdata = wd; be = m; rd = do_rd; wr = do_wr;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (get_resp(d)) got = 1'b1;
      else if (scramble) begin
        addr  = 16'($urandom);
        wdata = 16'($urandom);
      end
    end
    check_eq({tag, "_lat"}, got ? n : 99, lat[d]);
    rd = 1'b0; wr = 1'b0;
    i = (int'(a) / 2) % DEPTH;
    if (do_wr) begin
      if (m[0]) ref_mem[d][i][7:0]  = wd[7:0];
      if (m[1]) ref_mem[d][i][15:8] = wd[15:8];
      if (m == 2'b11) ref_known[d][i] = 1'b1;
      if (do_rd) ref_perr[d] = 1'b1;
    end else begin
      ref_rdata[d] = ref_mem[d][i];
    end
    check_eq({tag, "_rdata"}, get_rdata(d), ref_rdata[d]);
    check_eq({tag, "_perr"}, get_perr(d), ref_perr[d]);
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_pulse"}, get_resp(d), 1'b0);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel = 1'b0; addr = '0; wdata = '0; be = '0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < DEPTH; k++) ref_known[d][k] = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_resp0", bus0.mem_resp, 1'b0);
    check_eq("rst_rdata0", bus0.mem_rdata, 16'h0);
    check_eq("rst_perr0", bus0.protocol_err, 1'b0);
    check_eq("rst_resp1", bus1.mem_resp, 1'b0);
    check_eq("rst_rdata1", bus1.mem_rdata, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read after preload, full and partial writes, empty mask.
    txn(0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, 0, "preload");
    txn(0, 1, 0, 16'h0010, 16'h0000, 2'b00, 0, "rd_beef");
    check_eq("rd_beef_val", ref_rdata[0], 16'hBEEF);
    txn(0, 0, 1, 16'h0020, 16'h1234, 2'b11, 0, "wr_1234");
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 0, "rd_1234");
    txn(0, 0, 1, 16'h0020, 16'hAB00, 2'b10, 0, "wr_hi");
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 0, "rd_ab34");
    check_eq("rd_ab34_val", ref_rdata[0], 16'hAB34);
    txn(0, 0, 1, 16'h0020, 16'hFFFF, 2'b00, 0, "wr_nomask");
    txn(0, 1, 0, 16'h0020, 16'h0000, 2'b00, 0, "rd_nomask");

    // Inputs scrambled while BUSY must not affect the completion.
    txn(0, 0, 1, 16'h0024, 16'hCAFE, 2'b11, 1, "wr_scr");
    txn(0, 1, 0, 16'h0024, 16'h0000, 2'b00, 1, "rd_scr");

    // Reset during BUSY aborts a write.
    txn(0, 0, 1, 16'h0040, 16'h6666, 2'b11, 0, "wr_old");
    sel = 1'b0; addr = 16'h0040; wdata = 16'h7777; be = 2'b11; wr = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("abort_busy_resp", bus0.mem_resp, 1'b0);
    rst = 1'b1; wr = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("abort_rst_resp", bus0.mem_resp, 1'b0);
    check_eq("abort_rst_rdata", bus0.mem_rdata, 16'h0);
    rst = 1'b0;
    reset_model();
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check_eq("abort_late_resp", bus0.mem_resp, 1'b0);
    end
    txn(0, 1, 0, 16'h0040, 16'h0000, 2'b00, 0, "rd_old");
    check_eq("rd_old_val", ref_rdata[0], 16'h6666);

    // Read and write together: write wins, sticky error until reset.
    txn(0, 1, 1, 16'h0030, 16'h5555, 2'b11, 0, "dual");
    txn(0, 1, 0, 16'h0030, 16'h0000, 2'b00, 0, "rd_dual");
    check_eq("rd_dual_val", ref_rdata[0], 16'h5555);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_eq("perr_cleared", bus0.protocol_err, 1'b0);

    // LATENCY=1 instance with address aliasing.
    txn(1, 0, 1, 16'h0002, 16'h9A9A, 2'b11, 0, "l1_wr");
    txn(1, 1, 0, 16'h0202, 16'h0000, 2'b00, 0, "l1_alias");
    check_eq("l1_alias_val", ref_rdata[1], 16'h9A9A);

    // Random traffic on both instances over a small aliased window.
    for (int it = 0; it < 60; it++) begin
      int d;
      int idx;
      bit op_rd, op_wr;
      logic [15:0] a;
      d   = int'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 7));
      a   = 16'((($urandom_range(0, 127)) << 9) | (idx << 1) | $urandom_range(0, 1));
      op_rd = ($urandom_range(0, 1) == 1) && ref_known[d][idx];
      op_wr = !op_rd || ($urandom_range(0, 15) == 0);
      if (!ref_known[d][idx])
        txn(d, 0, 1, a, 16'($urandom), 2'b11, $urandom_range(0, 1) == 1, "rnd_init");
      else
        txn(d, op_rd, op_wr, a, 16'($urandom), 2'($urandom),
            $urandom_range(0, 1) == 1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
